axis_tx_scheduler: RTL and testbench
====================================

# axis_tx_scheduler

Packet-level round-robin scheduler that shares the single RS232 transmitter (`axis_to_rs232`) between several AXI-stream byte sources. It grants one source at a time and holds the grant for a whole packet or burst. Each granted burst is prefixed with a channel header byte, so the host can demultiplex the serial stream. The block sits between the source FIFOs and the transmitter's `idata`/`ivalid`/`iready` port.

## Interface
Parameters:
- `CHANNELS`, 4: number of requesters, 2..16.
- `MAX_BURST`, 64: maximum payload bytes per grant, ≥1.
- `HEADER_EN`, 1: 1 = emit header byte per grant; 0 = no header.

Ports:
- `clock`  in  1: clock; reset `resetn` is asynchronous, active-low; clock `clock`.
- `resetn`  in  1: asynchronous active-low reset.
- `idata`  in  8*CHANNELS: byte of channel k at bits [8k+7:8k].
- `ivalid`  in  CHANNELS: per-channel valid.
- `ilast`  in  CHANNELS: per-channel end-of-packet, qualified by `ivalid`.
- `iready`  out  CHANNELS: per-channel ready; at most one bit high.
- `odata`  out  8: byte to transmitter.
- `ovalid`  out  1: output valid.
- `oready`  in  1: transmitter ready.
- `grant`  out  CHANNELS: one-hot current owner; all zero in IDLE.

## Operation
- States: IDLE, PAYLOAD.
- The output register (`odata`, `ovalid`) is free when `!ovalid || oready`.
- IDLE, with the output register free and any `ivalid` set:
  - Pick the channel by round-robin, searching from `last+1` upward with wrap to 0. `last` is the previously granted index.
  - Set `grant` and `last` to that channel. Go to PAYLOAD with the burst counter at 0.
  - If HEADER_EN, load `odata` = {4'hF, index[3:0]} and set `ovalid` = 1 in the same cycle.
- In IDLE, `ilast` has no effect and `iready` is all zero.
- PAYLOAD: `iready[g]` = output register free (combinational from `ovalid`/`oready`); all other bits are 0.
- On a payload accept (`ivalid[g] && iready[g]`):
  - Load `odata` = byte of channel g and set `ovalid` = 1.
  - Increment the counter.
  - If `ilast[g]` or counter == MAX_BURST-1, return to IDLE and clear `grant`.
- When the output register is free and nothing is loaded, `ovalid` drops to 0.
- Counter width is $clog2(MAX_BURST+1). The counter never wraps because the grant ends at MAX_BURST bytes.
- A burst cut by MAX_BURST without `ilast` does not keep the grant. The channel re-arbitrates normally and gets a new header when granted again.
- A channel dropping `ivalid` mid-packet keeps the grant; the scheduler waits indefinitely. No timeout.
- Sources must hold `idata`/`ilast` stable while `ivalid && !iready`.
- Reset values:
  - state IDLE, `last` = CHANNELS-1 (so channel 0 has first priority);
  - `grant` = 0, `iready` = 0, `ovalid` = 0, `odata` = 8'h00, counter = 0.
- Reset mid-packet abandons the packet immediately, with no partial flush.

## Timing
- Header appears on `odata` one cycle after IDLE sees a request.
- First payload accept can occur in the cycle the header is accepted downstream (`oready`=1). With HEADER_EN=0 it can occur the cycle after the grant.
- Payload latency is 1 clock, input accept to `ovalid`.
- Full throughput (one byte per clock) is possible when `oready` is held high.
- Gap between bursts is one IDLE cycle. The last payload byte and the next header are never in the same register at once.
- Simultaneous `ovalid && oready` with a new load counts as replace, not stall.

## Structure
- Package `axis_tx_pkg`: state enum (IDLE, PAYLOAD) and header constant `HDR_TAG` = 4'hF.
- Sub-module `rr_arbiter` (CHANNELS): inputs request vector and last index; outputs one-hot grant and binary index. Purely combinational rotate-priority logic.
- The scheduler instantiates `rr_arbiter` and holds state, `last`, counter and the output register.

## Test plan
- Single source: ch2 sends 3 bytes 11,22,33 with `ilast` on 33, `oready`=1 → `odata` sequence F2,11,22,33, then `ovalid`=0 and `grant`=0.
- Contention: all 4 channels valid with 1-byte packets from reset → headers F0,F1,F2,F3 in order; the next round starts again at F0.
- Burst cap: MAX_BURST=4, ch1 sends 10 bytes with `ilast` only on the 10th, ch3 idle → F1+4 bytes, F1+4 bytes, F1+2 bytes. With ch3 valid, F3's packet is interleaved after each F1 burst.
- Backpressure: `oready` toggles 1010… during a 5-byte packet → each byte held stable until accepted, no loss or duplication, `iready[g]` low while `ovalid && !oready`.
- Stall mid-packet: ch0 drops `ivalid` for 20 cycles after byte 2 while ch1 is valid → grant stays on ch0, no F1 emitted until ch0's `ilast`.
- Reset mid-packet: assert `resetn`=0 during byte 3 → next cycle all outputs are at reset values; after release ch0 wins first.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// rtl/axis_tx_pkg.sv - shared types and constants for the RS232 transmit scheduler
package axis_tx_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } sched_state_t;

    localparam logic [3:0] HDR_TAG = 4'hF;

    function automatic logic [7:0] header_byte(input logic [3:0] index);
        return {HDR_TAG, index};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority arbiter, search starts after last winner
module rr_arbiter #(
    parameter  int CHANNELS = 4,
    localparam int IDX_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [IDX_W-1:0]    last,
    output logic [CHANNELS-1:0] grant,
    output logic [IDX_W-1:0]    index
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = (int'(last) + i) % CHANNELS;
            if (!found && request[cand]) begin
                found       = 1'b1;
                index       = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_tx_scheduler.sv
// rtl/axis_tx_scheduler.sv - packet-level round-robin mux of byte streams onto one RS232 transmitter
module axis_tx_scheduler
    import axis_tx_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 64,
    parameter bit HEADER_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [8*CHANNELS-1:0] idata,
    input  logic [CHANNELS-1:0]   ivalid,
    input  logic [CHANNELS-1:0]   ilast,
    output logic [CHANNELS-1:0]   iready,
    output logic [7:0]            odata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [CHANNELS-1:0]   grant
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    sched_state_t        state;
    sched_state_t        state_next;
    logic [IDX_W-1:0]    last;
    logic [CNT_W-1:0]    count;
    logic [CHANNELS-1:0] arb_grant;
    logic [IDX_W-1:0]    arb_index;
    logic                out_free;
    logic                start;
    logic                accept;
    logic                burst_end;
    logic [7:0]          sel_data;
    logic                sel_last;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arbiter (
        .request (ivalid),
        .last    (last),
        .grant   (arb_grant),
        .index   (arb_index)
    );

    // While a burst is open, last is the owner's index.
    assign out_free = !ovalid || oready;
    assign sel_data = idata[8*int'(last) +: 8];
    assign sel_last = ilast[last];
    assign iready   = (state == PAYLOAD && out_free) ? grant : '0;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        burst_end  = 1'b0;
        case (state)
            IDLE: begin
                if (out_free && |ivalid) begin
                    start      = 1'b1;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                accept    = out_free && ivalid[last];
                burst_end = accept && (sel_last || count == CNT_W'(MAX_BURST - 1));
                if (burst_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last   <= IDX_W'(CHANNELS - 1);
            count  <= '0;
            grant  <= '0;
            odata  <= 8'h00;
            ovalid <= 1'b0;
        end else if (start) begin
            grant <= arb_grant;
            last  <= arb_index;
            count <= '0;
            if (HEADER_EN) begin
                odata  <= header_byte(4'(arb_index));
                ovalid <= 1'b1;
            end else begin
                ovalid <= 1'b0;
            end
        end else if (accept) begin
            odata  <= sel_data;
            ovalid <= 1'b1;
            count  <= count + 1'b1;
            if (burst_end) begin
                grant <= '0;
            end
        end else if (out_free) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_tx_scheduler.sv
// tb/tb_axis_tx_scheduler.sv - randomized bench for axis_tx_scheduler against a packet-level model
module tb_axis_tx_scheduler;

    localparam int CH    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 128;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [8*CH-1:0] idata;
    logic [CH-1:0]   ivalid;
    logic [CH-1:0]   ilast;
    logic [CH-1:0]   iready;
    logic [7:0]      odata;
    logic            ovalid;
    logic            oready;
    logic [CH-1:0]   grant;

    axis_tx_scheduler #(
        .CHANNELS  (CH),
        .MAX_BURST (MB),
        .HEADER_EN (1'b1)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata),
        .ivalid (ivalid),
        .ilast  (ilast),
        .iready (iready),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready),
        .grant  (grant)
    );

    always #5 clock = ~clock;

    logic [8:0] src_mem [CH][DEPTH];
    int         src_head [CH] = '{default: 0};
    int         src_tail [CH] = '{default: 0};
    logic [7:0] exp_q[$];
    int         model_last = CH - 1;
    int         n_checks = 0;
    int         n_pass = 0;
    bit         lat_pend = 1'b0;
    logic [7:0] lat_byte;
    int         oready_mode = 0;
    int         stall_pct = 0;
    bit         toggle = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b, input bit is_last);
        src_mem[ch][src_tail[ch] % DEPTH] = {is_last, b};
        src_tail[ch]++;
    endtask

    // Packet-level model: pending packets in, expected serial byte stream out.
    task automatic build_expected();
        int         h [CH];
        int         pick;
        int         n;
        logic [8:0] e;
        for (int c = 0; c < CH; c++) h[c] = src_head[c];
        while (1) begin
            pick = -1;
            for (int i = 1; i <= CH; i++) begin
                int c = (model_last + i) % CH;
                if (pick < 0 && h[c] < src_tail[c]) pick = c;
            end
            if (pick < 0) break;
            model_last = pick;
            exp_q.push_back(8'hF0 | 8'(pick));
            n = 0;
            do begin
                e = src_mem[pick][h[pick] % DEPTH];
                h[pick]++;
                n++;
                exp_q.push_back(e[7:0]);
            end while (!e[8] && n < MB && h[pick] < src_tail[pick]);
        end
    endtask

    task automatic drive_inputs();
        toggle = ~toggle;
        case (oready_mode)
            0:       oready = 1'b1;
            1:       oready = toggle;
            default: oready = ($urandom_range(0, 99) < 65);
        endcase
        for (int k = 0; k < CH; k++) begin
            if (src_head[k] < src_tail[k]) begin
                idata[8*k +: 8] = src_mem[k][src_head[k] % DEPTH][7:0];
                ilast[k]        = src_mem[k][src_head[k] % DEPTH][8];
                ivalid[k]       = !(grant[k] && ($urandom_range(0, 99) < stall_pct));
            end else begin
                idata[8*k +: 8] = 8'h00;
                ilast[k]        = 1'b0;
                ivalid[k]       = 1'b0;
            end
        end
    endtask

    initial begin
        idata  = '0;
        ivalid = '0;
        ilast  = '0;
        oready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            drive_inputs();
        end
    end

    initial forever begin
        @(negedge clock);
        if (!resetn) begin
            lat_pend = 1'b0;
        end else begin
            if (lat_pend) begin
                check("lat_ovalid", 32'(ovalid), 32'd1);
                check("lat_odata", 32'(odata), 32'(lat_byte));
                lat_pend = 1'b0;
            end
            if (ovalid && oready) begin
                if (exp_q.size() == 0) check("extra_byte", 32'(odata), 32'h100);
                else check("odata", 32'(odata), 32'(exp_q.pop_front()));
            end
            check("iready_onehot0", 32'($onehot0(iready)), 32'd1);
            check("iready_in_grant", 32'(iready & ~grant), 32'd0);
            if (ovalid && !oready) check("iready_stall", 32'(iready), 32'd0);
            for (int k = 0; k < CH; k++) begin
                if (ivalid[k] && iready[k]) begin
                    lat_pend = 1'b1;
                    lat_byte = idata[8*k +: 8];
                    src_head[k]++;
                end
            end
        end
    end

    task automatic sync();
        @(negedge clock);
        #2;
    endtask

    task automatic apply_reset();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_odata", 32'(odata), 32'h00);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_iready", 32'(iready), 32'd0);
        for (int k = 0; k < CH; k++) src_tail[k] = src_head[k];
        exp_q.delete();
        model_last = CH - 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic run_phase(input string name, input int budget);
        int cyc = 0;
        build_expected();
        while (exp_q.size() != 0 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        #1;
        check({name, "_ovalid_idle"}, 32'(ovalid), 32'd0);
        check({name, "_grant_idle"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int total;
        int cyc;
        apply_reset();

        sync();
        push_byte(2, 8'h11, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        run_phase("single", 100);

        apply_reset();
        sync();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < CH; k++) push_byte(k, 8'(8'hA0 + 16*r + k), 1'b1);
        run_phase("contend", 200);

        sync();
        for (int b = 0; b < 10; b++) push_byte(1, 8'(8'h30 + b), b == 9);
        run_phase("cap", 200);

        sync();
        for (int b = 0; b < 10; b++) push_byte(1, 8'(8'h40 + b), b == 9);
        for (int b = 0; b < 6; b++) push_byte(3, 8'(8'h60 + b), b[0]);
        run_phase("cap_mix", 300);

        sync();
        oready_mode = 1;
        for (int b = 0; b < 5; b++) push_byte(0, 8'(8'h71 + b), b == 4);
        run_phase("backpressure", 200);

        sync();
        oready_mode = 0;
        stall_pct   = 60;
        for (int b = 0; b < 4; b++) push_byte(0, 8'(8'h81 + b), b == 3);
        push_byte(1, 8'h91, 1'b0);
        push_byte(1, 8'h92, 1'b1);
        run_phase("stall", 500);

        for (int r = 0; r < 8; r++) begin
            sync();
            oready_mode = 2;
            stall_pct   = 30;
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int np = $urandom_range(1, 3);
                    for (int p = 0; p < np; p++) begin
                        int len = $urandom_range(1, 9);
                        for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), b == len - 1);
                    end
                end
            end
            run_phase("random", 2000);
        end

        sync();
        oready_mode = 0;
        stall_pct   = 0;
        for (int b = 0; b < 8; b++) push_byte(0, 8'(8'hC0 + b), b == 7);
        for (int b = 0; b < 3; b++) push_byte(1, 8'(8'hD0 + b), b == 2);
        build_expected();
        total = exp_q.size();
        cyc   = 0;
        while (exp_q.size() > total - 4 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("midpkt_progress", 32'(exp_q.size() <= total - 4), 32'd1);
        apply_reset();

        sync();
        push_byte(3, 8'hE1, 1'b0);
        push_byte(3, 8'hE2, 1'b1);
        push_byte(0, 8'hE5, 1'b0);
        push_byte(0, 8'hE6, 1'b1);
        run_phase("after_reset", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
